// File: rtl/serdes_link_ctrl_pkg.sv
// Shared types and constants for the SerDes link controller.
package serdes_ctrl_pkg;

    // Link FSM states; the encoding is visible on the state output.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PWRUP   = 3'd1,
        TRAIN   = 3'd2,
        LINK_UP = 3'd3
    } link_state_e;

    // Training / idle-fill comma character.
    localparam logic [9:0] COMMA = 10'b0011111010;

    // Default parameter values.
    localparam int unsigned DEF_WIDTH         = 10;
    localparam int unsigned DEF_PWRUP_CYCLES  = 16;
    localparam int unsigned DEF_LOCK_COUNT    = 4;
    localparam int unsigned DEF_LOSS_COUNT    = 3;
    localparam int unsigned DEF_TRAIN_TIMEOUT = 64;

endpackage : serdes_ctrl_pkg

// File: rtl/serdes_link_ctrl_consec_counter.sv
// Saturating consecutive-event counter: reached_o is high once N hits have
// been seen back to back with no intervening clear.
module serdes_consec_counter #(
    parameter int unsigned N = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic hit_i,
    input  logic clear_i,
    output logic reached_o
);

    localparam int unsigned        CW   = $clog2(N + 1);
    localparam logic [CW-1:0]      CMAX = CW'(N);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: clear has priority, increments stop at N.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (hit_i && (cnt_q != CMAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign reached_o = (cnt_q == CMAX);

endmodule : serdes_consec_counter

// File: rtl/serdes_link_ctrl.sv
// SerDes link controller: power-up settle, comma training with timeout,
// and a simple parallel datapath once the link is up.
module serdes_link_ctrl
    import serdes_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH         = DEF_WIDTH,
    parameter int unsigned PWRUP_CYCLES  = DEF_PWRUP_CYCLES,
    parameter int unsigned LOCK_COUNT    = DEF_LOCK_COUNT,
    parameter int unsigned LOSS_COUNT    = DEF_LOSS_COUNT,
    parameter int unsigned TRAIN_TIMEOUT = DEF_TRAIN_TIMEOUT
) (
    input  logic             parallel_clk,
    input  logic             serdes_reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] Tx0,
    input  logic [WIDTH-1:0] Rx0,
    input  logic             rx_los,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             link_up,
    output logic             train_fail,
    output logic [7:0]       fail_cnt,
    output logic [2:0]       state
);

    localparam int unsigned      PW_W    = $clog2(PWRUP_CYCLES + 1);
    localparam int unsigned      TO_W    = $clog2(TRAIN_TIMEOUT + 1);
    localparam logic [PW_W-1:0]  PW_LAST = PW_W'(PWRUP_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TRAIN_TIMEOUT - 1);
    localparam logic [WIDTH-1:0] COMMA_W = WIDTH'(COMMA);

    link_state_e      state_q, state_d;
    logic [PW_W-1:0]  pwr_cnt_q, pwr_cnt_d;
    logic [TO_W-1:0]  timer_q, timer_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             train_fail_q, train_fail_d;
    logic [7:0]       fail_cnt_q, fail_cnt_d;
    logic             in_train, in_link, rx_is_comma;
    logic             lock, loss, timeout;

    assign in_train    = (state_q == TRAIN);
    assign in_link     = (state_q == LINK_UP);
    assign rx_is_comma = (Rx0 == COMMA_W);

    serdes_consec_counter #(.N(LOCK_COUNT)) u_lock_cnt (
        .clk_i     (parallel_clk),
        .rst_ni    (serdes_reset),
        .hit_i     (in_train && rx_is_comma),
        .clear_i   (!in_train || !rx_is_comma),
        .reached_o (lock)
    );

    serdes_consec_counter #(.N(LOSS_COUNT)) u_loss_cnt (
        .clk_i     (parallel_clk),
        .rst_ni    (serdes_reset),
        .hit_i     (in_link && rx_los),
        .clear_i   (!in_link || !rx_los),
        .reached_o (loss)
    );

    // Next-state logic; disable overrides everything, lock beats timeout.
    always_comb begin
        state_d = state_q;
        timeout = 1'b0;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = PWRUP;
                PWRUP:   if (pwr_cnt_q == PW_LAST) state_d = TRAIN;
                TRAIN: begin
                    if (lock) begin
                        state_d = LINK_UP;
                    end else if (timer_q == TO_LAST) begin
                        state_d = PWRUP;
                        timeout = 1'b1;
                    end
                end
                LINK_UP: if (loss) state_d = TRAIN;
                default: state_d = IDLE;
            endcase
        end
    end

    // Counters, transmit word selection, receive capture and failure tracking.
    always_comb begin
        pwr_cnt_d = in_train ? '0 : ((state_q == PWRUP) ? pwr_cnt_q + 1'b1 : '0);
        timer_d   = in_train ? timer_q + 1'b1 : '0;
        // Tx0 follows the state being entered so it is already correct on arrival.
        case (state_d)
            LINK_UP: tx_d = (in_link && tx_valid) ? tx_data : COMMA_W;
            TRAIN:   tx_d = COMMA_W;
            default: tx_d = '0;
        endcase
        rx_data_d    = in_link ? Rx0 : '0;
        rx_valid_d   = in_link && (state_d == LINK_UP) && !rx_is_comma;
        train_fail_d = timeout;
        fail_cnt_d   = (timeout && (fail_cnt_q != 8'hFF)) ? fail_cnt_q + 8'd1 : fail_cnt_q;
    end

    // State and datapath registers.
    always_ff @(posedge parallel_clk or negedge serdes_reset) begin
        if (!serdes_reset) begin
            state_q      <= IDLE;
            pwr_cnt_q    <= '0;
            timer_q      <= '0;
            tx_q         <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            train_fail_q <= 1'b0;
            fail_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            pwr_cnt_q    <= pwr_cnt_d;
            timer_q      <= timer_d;
            tx_q         <= tx_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            train_fail_q <= train_fail_d;
            fail_cnt_q   <= fail_cnt_d;
        end
    end

    assign state      = state_q;
    assign link_up    = in_link;
    assign tx_ready   = in_link;
    assign Tx0        = tx_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign train_fail = train_fail_q;
    assign fail_cnt   = fail_cnt_q;

endmodule : serdes_link_ctrl

// File: tb/tb_serdes_link_ctrl.sv
// Testbench for serdes_link_ctrl: directed scenarios plus randomized traffic,
// all checked every cycle against a behavioural reference model.
module tb_serdes_link_ctrl;
    import serdes_ctrl_pkg::*;

    localparam int W    = 10;
    localparam int PWR  = 16;
    localparam int LOCK = 4;
    localparam int LOSS = 3;
    localparam int TMO  = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         enable = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic         tx_valid = 1'b0;
    logic [W-1:0] Rx0 = '0;
    logic         rx_los = 1'b0;
    logic         tx_ready, rx_valid, link_up, train_fail;
    logic [W-1:0] Tx0, rx_data;
    logic [7:0]   fail_cnt;
    logic [2:0]   state;

    int checks = 0;
    int errors = 0;

    serdes_link_ctrl #(
        .WIDTH(W), .PWRUP_CYCLES(PWR), .LOCK_COUNT(LOCK),
        .LOSS_COUNT(LOSS), .TRAIN_TIMEOUT(TMO)
    ) dut (
        .parallel_clk(clk), .serdes_reset(rst_n), .enable(enable),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .Tx0(Tx0), .Rx0(Rx0), .rx_los(rx_los), .rx_data(rx_data),
        .rx_valid(rx_valid), .link_up(link_up), .train_fail(train_fail),
        .fail_cnt(fail_cnt), .state(state)
    );

    always #5 clk = ~clk;

    // Reference model: current state, cycles spent in it, and the per-cycle
    // samples (comma seen / loss seen) taken during the current visit.
    link_state_e  m_st;
    int           m_dwell;
    int           m_fail;
    bit           m_tf, m_rxv;
    logic [W-1:0] m_tx, m_rxd;
    bit           hist[$];

    function automatic void model_reset();
        m_st = IDLE; m_dwell = 0; m_fail = 0; m_tf = 0; m_rxv = 0;
        m_tx = '0; m_rxd = '0; hist.delete();
    endfunction

    function automatic bit recent_all(int n);
        if (hist.size() < n) return 1'b0;
        for (int i = hist.size() - n; i < hist.size(); i++)
            if (!hist[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_edge();
        link_state_e nst;
        bit          fail;
        bit          smp;
        nst  = m_st;
        fail = 1'b0;
        smp  = (m_st == TRAIN) ? (Rx0 == COMMA) : rx_los;
        if (!enable) nst = IDLE;
        else if (m_st == IDLE) nst = PWRUP;
        else if (m_st == PWRUP) begin
            if (m_dwell == PWR - 1) nst = TRAIN;
        end else if (m_st == TRAIN) begin
            if (recent_all(LOCK)) nst = LINK_UP;
            else if (m_dwell == TMO - 1) begin nst = PWRUP; fail = 1'b1; end
        end else begin
            if (recent_all(LOSS)) nst = TRAIN;
        end
        m_rxd = (m_st == LINK_UP) ? Rx0 : '0;
        m_rxv = (m_st == LINK_UP) && (nst == LINK_UP) && (Rx0 != COMMA);
        if (nst == LINK_UP) m_tx = (m_st == LINK_UP && tx_valid) ? tx_data : COMMA;
        else if (nst == TRAIN) m_tx = COMMA;
        else m_tx = '0;
        m_tf = fail;
        if (fail && m_fail < 255) m_fail++;
        if (nst != m_st) begin
            hist.delete();
            m_dwell = 0;
        end else begin
            hist.push_back(smp);
            if (hist.size() > 8) void'(hist.pop_front());
            m_dwell++;
        end
        m_st = nst;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("state", 32'(state), 32'(m_st));
        chk("link_up", 32'(link_up), 32'(m_st == LINK_UP));
        chk("tx_ready", 32'(tx_ready), 32'(m_st == LINK_UP));
        chk("Tx0", 32'(Tx0), 32'(m_tx));
        chk("rx_data", 32'(rx_data), 32'(m_rxd));
        chk("rx_valid", 32'(rx_valid), 32'(m_rxv));
        chk("train_fail", 32'(train_fail), 32'(m_tf));
        chk("fail_cnt", 32'(fail_cnt), 32'(m_fail));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Drop to IDLE and retrain on held commas until the model reports LINK_UP.
    task automatic reach_link();
        int guard;
        enable = 1'b0; rx_los = 1'b0; tx_valid = 1'b0;
        tick();
        enable = 1'b1; Rx0 = COMMA;
        guard = 0;
        while (m_st != LINK_UP && guard < 40) begin tick(); guard++; end
        chk("reach_link", 32'(link_up), 32'd1);
    endtask

    initial begin
        int t;
        bit saw_fail;
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        compare_all();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;

        // Bring-up with commas held: 1 + 16 edges to TRAIN, 5 more to LINK_UP.
        enable = 1'b1; Rx0 = COMMA;
        ticks(16);
        chk("bringup_pwrup", 32'(state), 32'(PWRUP));
        tick();
        chk("bringup_train", 32'(state), 32'(TRAIN));
        chk("bringup_tx_comma", 32'(Tx0), 32'(COMMA));
        ticks(4);
        chk("bringup_not_yet", 32'(link_up), 32'd0);
        tick();
        chk("bringup_link", 32'(link_up), 32'd1);

        // Mismatch restarts the lock run.
        enable = 1'b0; tick();
        enable = 1'b1; Rx0 = '0;
        ticks(17);
        chk("mm_train", 32'(state), 32'(TRAIN));
        for (int i = 0; i < 8; i++) begin
            Rx0 = (i == 3) ? 10'h155 : COMMA;
            tick();
            chk("mm_no_link", 32'(link_up), 32'd0);
        end
        Rx0 = COMMA; tick();
        chk("mm_link", 32'(link_up), 32'd1);

        // Datapath.
        tx_valid = 1'b1; tx_data = 10'h2A5; Rx0 = 10'h133;
        tick();
        chk("dp_tx", 32'(Tx0), 32'h2A5);
        chk("dp_rx", 32'(rx_data), 32'h133);
        chk("dp_rxv", 32'(rx_valid), 32'd1);
        tx_valid = 1'b0; Rx0 = COMMA;
        tick();
        chk("dp_idle_fill", 32'(Tx0), 32'(COMMA));
        chk("dp_rxv_comma", 32'(rx_valid), 32'd0);

        // Loss of signal: 1,1,0,1,1,1.
        for (int i = 0; i < 6; i++) begin
            rx_los = (i != 2);
            tick();
            if (i < 5) chk("los_hold", 32'(link_up), 32'd1);
        end
        rx_los = 1'b0; tick();
        chk("los_train", 32'(state), 32'(TRAIN));
        chk("los_drop", 32'(link_up), 32'd0);

        // Randomized traffic, retraining, loss bursts and occasional disable.
        for (int i = 0; i < 600; i++) begin
            Rx0      = ($urandom_range(0, 3) != 0) ? COMMA : W'($urandom);
            tx_valid = $urandom_range(0, 1);
            tx_data  = W'($urandom);
            rx_los   = ($urandom_range(0, 7) == 0);
            enable   = ($urandom_range(0, 99) != 0);
            tick();
        end

        // Abort by disable in LINK_UP.
        reach_link();
        enable = 1'b0; tx_valid = 1'b1; tx_data = 10'h3C3;
        tick();
        chk("abort_idle", 32'(state), 32'(IDLE));
        chk("abort_link", 32'(link_up), 32'd0);
        chk("abort_tx", 32'(Tx0), 32'd0);
        tx_valid = 1'b0;

        // Asynchronous reset in TRAIN.
        enable = 1'b1; Rx0 = '0;
        ticks(18);
        chk("rst_pre_train", 32'(state), 32'(TRAIN));
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk); #1;
        compare_all();
        rst_n = 1'b1;

        // Timeout: first failure 1 + 16 + 64 edges after enable, then every 80.
        for (int k = 1; k <= 3; k++) begin
            t = 0;
            do begin tick(); t++; end while (train_fail !== 1'b1 && t < 200);
            chk("tmo_gap", 32'(t), (k == 1) ? 32'd81 : 32'd80);
            chk("tmo_cnt", 32'(fail_cnt), 32'(k));
        end

        // Lock in the last TRAIN cycle beats the timeout.
        saw_fail = 1'b0; t = 0;
        while (m_st != LINK_UP && t < 200) begin
            Rx0 = (m_st == TRAIN && m_dwell >= TMO - 5 && m_dwell <= TMO - 2) ? COMMA : '0;
            tick();
            if (train_fail === 1'b1) saw_fail = 1'b1;
            t++;
        end
        chk("tie_link", 32'(link_up), 32'd1);
        chk("tie_no_pulse", 32'(saw_fail), 32'd0);
        chk("tie_cnt", 32'(fail_cnt), 32'd3);

        // Saturation of the failure count.
        enable = 1'b0; Rx0 = '0; tick();
        enable = 1'b1;
        ticks(300 * 80 + 20);
        chk("sat_cnt", 32'(fail_cnt), 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_serdes_link_ctrl

// File: doc/serdes_link_ctrl.md
SERDES_LINK_CTRL -- requirements
Module: serdes_link_ctrl

Interface
REQ-001 Parameter WIDTH, default 10: parallel word width on Tx0/Rx0.
REQ-002 Parameter PWRUP_CYCLES, default 16: power-up settle cycles before training.
REQ-003 Parameters: LOCK_COUNT, default 4, consecutive comma matches needed for lock; LOSS_COUNT, default 3, consecutive rx_los cycles that declare loss; TRAIN_TIMEOUT, default 64, training cycles allowed before failure.
REQ-004 Ports are, with clock and reset first:
- parallel_clk  in  1  sole clock.
- serdes_reset  in  1  asynchronous, active-low reset.
- enable  in  1  link enable.
- tx_data  in  WIDTH  user transmit word.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  user word accepted this cycle.
- Tx0  out  WIDTH  parallel word to serializer.
- Rx0  in  WIDTH  parallel word from deserializer.
- rx_los  in  1  loss-of-signal indication.
- rx_data  out  WIDTH  received user word.
- rx_valid  out  1  rx_data valid.
- link_up  out  1  link trained.
- train_fail  out  1  one-cycle failure pulse.
- fail_cnt  out  8  saturating training-failure count.
- state  out  3  current FSM state encoding.

Function
REQ-005 FSM states SHALL be IDLE, PWRUP, TRAIN and LINK_UP; state SHALL show the registered current state.
REQ-006 In any state, enable=0 SHALL force IDLE on the next cycle, overriding all other transitions.
REQ-007 From IDLE with enable=1, the FSM SHALL go to PWRUP and clear the power-up counter.
REQ-008 PWRUP SHALL last exactly PWRUP_CYCLES cycles, then go to TRAIN with the match counter and timeout timer cleared.
REQ-009 In TRAIN, Tx0 SHALL carry COMMA (10'b0011111010); each cycle Rx0==COMMA increments the match counter, and any mismatch clears it.
REQ-010 When the match counter reaches LOCK_COUNT, the FSM SHALL enter LINK_UP on the next edge.
REQ-011 If TRAIN_TIMEOUT cycles elapse in TRAIN without lock, the block SHALL pulse train_fail for one cycle, increment fail_cnt saturating at 255, and return to PWRUP.
REQ-012 If lock and timeout occur in the same cycle, lock SHALL win: no train_fail pulse, and fail_cnt is unchanged.
REQ-013 In LINK_UP, tx_ready SHALL be 1; when tx_valid=1, Tx0 SHALL take tx_data on the next edge, otherwise Tx0 SHALL take COMMA as idle fill.
REQ-014 In LINK_UP, rx_data SHALL register Rx0 with 1-cycle latency; rx_valid SHALL be 1 exactly when the registered word is not COMMA.
REQ-015 In LINK_UP, LOSS_COUNT consecutive cycles of rx_los=1 SHALL drop link_up and return the FSM to TRAIN; any cycle with rx_los=0 SHALL clear the loss counter.
REQ-016 link_up SHALL be 1 only in LINK_UP; outside LINK_UP, tx_ready=0 and rx_valid=0.
REQ-017 In IDLE and PWRUP, Tx0 SHALL be all zeros.

Reset
REQ-018 While serdes_reset=0, the block SHALL asynchronously set: state=IDLE, Tx0=0, rx_data=0, rx_valid=0, link_up=0, tx_ready=0, train_fail=0, fail_cnt=0, and all counters to 0.
REQ-019 Reset asserted mid-operation, including in LINK_UP, SHALL take effect immediately with no completion of the current word.
REQ-020 Reset deassertion SHALL be synchronized to parallel_clk in the instantiating environment; the block SHALL leave IDLE no earlier than the first edge after deassertion.

Structure
REQ-021 Package serdes_ctrl_pkg SHALL hold the state enum, the COMMA constant and the default parameter values.
REQ-022 A sub-module serdes_consec_counter (saturating consecutive-event counter: inputs hit and clear; output reached at threshold N) SHALL be instantiated twice, once for lock and once for loss.

Verification
REQ-023 Bring-up: reset, then enable=1 with Rx0=COMMA held -> state TRAIN after 16 PWRUP cycles; link_up=1 once 4 matches are counted plus 1 cycle.
REQ-024 Mismatch: in TRAIN, Rx0=COMMA,COMMA,COMMA,10'h155,COMMA x4 -> link_up rises only after the second run of 4.
REQ-025 Timeout: Rx0=10'h000 held -> train_fail pulses once every 64 TRAIN cycles (plus 16 PWRUP); fail_cnt goes 1, 2, 3...; force 300 failures -> fail_cnt=255.
REQ-026 Datapath: in LINK_UP, tx_valid=1 with tx_data=10'h2A5 -> Tx0=10'h2A5 the next cycle; Rx0=10'h133 -> rx_data=10'h133 and rx_valid=1 the next cycle; Rx0=COMMA -> rx_valid=0.
REQ-027 Loss: rx_los=1,1,0,1,1,1 in LINK_UP -> link_up falls only after the third consecutive 1, and the FSM enters TRAIN.
REQ-028 Abort: enable=0 in LINK_UP -> IDLE, link_up=0, Tx0=0 the next cycle; serdes_reset=0 in TRAIN -> all outputs at reset values immediately.
